// File: rtl/kv_line_fill.sv
`timescale 1ns/1ps
// kv_line_fill: cache line-fill engine. Accepts a miss address, issues
// LINE_SIZE in-order word reads starting at the line base, assembles the
// returned words into a line buffer and hands the full line to the cache.
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_fetch_addr/valid, o_fetch_ready   fill request from the cache
//   o_fetch_data/valid, i_fetch_ready   assembled line back to the cache
//   o_mem_addr/valid, i_mem_ready       word read request to memory
//   i_mem_rdata/rvalid, o_mem_rready    in-order read responses
module kv_line_fill #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_SIZE  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  input  logic                  i_fetch_valid,
  output logic                  o_fetch_ready,
  output logic [DATA_WIDTH-1:0] o_fetch_data [LINE_SIZE],
  output logic                  o_fetch_valid,
  input  logic                  i_fetch_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_rvalid,
  output logic                  o_mem_rready
);

  localparam int unsigned OFS = $clog2(LINE_SIZE);
  localparam int unsigned CW  = OFS + 1;
  localparam logic [CW-1:0]         LINE_CNT = CW'(LINE_SIZE);
  localparam logic [CW-1:0]         LAST_CNT = CW'(LINE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(LINE_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         req_q, req_d;
  logic [CW-1:0]         rsp_q, rsp_d;
  logic                  wr_en;
  logic                  req_take;
  logic                  rsp_take;
  logic                  fetch_ready_d;
  logic                  fetch_valid_d;
  logic                  mem_valid_d;
  logic                  mem_rready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    req_d    = req_q;
    rsp_d    = rsp_q;
    wr_en    = 1'b0;
    req_take = o_mem_valid & i_mem_ready;
    rsp_take = i_mem_rvalid & o_mem_rready;

    case (state_q)
      IDLE: begin
        if (i_fetch_valid && o_fetch_ready) begin
          base_d  = i_fetch_addr & ~OFS_MASK;
          req_d   = '0;
          rsp_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Request and response beats are independent; both may land in one cycle.
        if (req_take && (req_q < LINE_CNT)) begin
          req_d = req_q + CW'(1);
        end
        if (rsp_take) begin
          wr_en = 1'b1;
          rsp_d = rsp_q + CW'(1);
          if (rsp_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (i_fetch_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fetch_ready_d = (state_d == IDLE);
    fetch_valid_d = (state_d == DONE);
    mem_rready_d  = (state_d == BUSY);
    mem_valid_d   = (state_d == BUSY) && (req_d < LINE_CNT);
    // Address only moves on an accepted beat, so it is stable under backpressure.
    mem_addr_d    = base_d | ADDR_WIDTH'(req_d[OFS-1:0]);
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      req_q         <= '0;
      rsp_q         <= '0;
      o_fetch_ready <= 1'b0;
      o_fetch_valid <= 1'b0;
      o_mem_valid   <= 1'b0;
      o_mem_rready  <= 1'b0;
      o_mem_addr    <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      req_q         <= req_d;
      rsp_q         <= rsp_d;
      o_fetch_ready <= fetch_ready_d;
      o_fetch_valid <= fetch_valid_d;
      o_mem_valid   <= mem_valid_d;
      o_mem_rready  <= mem_rready_d;
      o_mem_addr    <= mem_addr_d;
    end
  end

  // Line buffer; written only by accepted response beats in BUSY.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < LINE_SIZE; k++) begin
        o_fetch_data[k] <= '0;
      end
    end else if (wr_en) begin
      o_fetch_data[rsp_q[OFS-1:0]] <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_kv_line_fill.sv
`timescale 1ns/1ps
// Bench for kv_line_fill: directed scenarios plus randomized fills against a
// word-addressed memory model (word(a) = a ^ salt) and line-level expectations.
module tb_kv_line_fill;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned LS = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [AW-1:0] i_fetch_addr = '0;
  logic          i_fetch_valid = 1'b0;
  logic          o_fetch_ready;
  logic [DW-1:0] o_fetch_data [LS];
  logic          o_fetch_valid;
  logic          i_fetch_ready = 1'b0;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_valid;
  logic          i_mem_ready = 1'b1;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          i_mem_rvalid = 1'b0;
  logic          o_mem_rready;

  kv_line_fill #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_fetch_addr  (i_fetch_addr),
    .i_fetch_valid (i_fetch_valid),
    .o_fetch_ready (o_fetch_ready),
    .o_fetch_data  (o_fetch_data),
    .o_fetch_valid (o_fetch_valid),
    .i_fetch_ready (i_fetch_ready),
    .o_mem_addr    (o_mem_addr),
    .o_mem_valid   (o_mem_valid),
    .i_mem_ready   (i_mem_ready),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_rvalid  (i_mem_rvalid),
    .o_mem_rready  (o_mem_rready)
  );

  always #5 i_clk = ~i_clk;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   salt = '0;
  logic          inj_valid = 1'b0;
  logic [31:0]   inj_data = '0;
  bit            rand_ready = 1'b0;
  bit            ready_seq [$];
  logic [31:0]   issued [$];
  int            rsp_seen = 0;
  logic          hold_pv = 1'b0;
  logic          hold_pr = 1'b1;
  logic [31:0]   hold_pa = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: one-cycle read latency, ready pattern from a queue or random.
  always begin : responder
    logic        acc;
    logic [31:0] a;
    @(negedge i_clk);
    acc = o_mem_valid && i_mem_ready;
    a   = o_mem_addr;
    if (acc) issued.push_back(a);
    if (i_mem_rvalid && o_mem_rready) rsp_seen++;
    if (!i_rst && hold_pv && !hold_pr) begin
      chk("mem_hold_valid", 64'(o_mem_valid), 64'd1);
      chk("mem_hold_addr", 64'(o_mem_addr), 64'(hold_pa));
    end
    hold_pv = o_mem_valid;
    hold_pr = i_mem_ready;
    hold_pa = o_mem_addr;
    @(posedge i_clk);
    #1;
    i_mem_rvalid = acc || inj_valid;
    i_mem_rdata  = acc ? mem_word(a) : inj_data;
    if (o_mem_valid) begin
      if (ready_seq.size() > 0) i_mem_ready = ready_seq.pop_front();
      else if (rand_ready)      i_mem_ready = 1'($urandom_range(0, 1));
      else                      i_mem_ready = 1'b1;
    end else begin
      i_mem_ready = 1'b1;
    end
  end

  // Present a request and return just after the accepting edge.
  task automatic request(input logic [31:0] addr, input bit keep);
    int n;
    n = 0;
    i_fetch_addr  = addr;
    i_fetch_valid = 1'b1;
    while (!o_fetch_ready && n < 100) begin
      @(posedge i_clk); #1; n++;
    end
    chk("req_ready_timeout", 64'(o_fetch_ready), 64'd1);
    @(posedge i_clk); #1;
    if (!keep) i_fetch_valid = 1'b0;
    issued.delete();
  endtask

  // Cycles from the request handshake cycle (0) to the first o_fetch_valid cycle.
  task automatic wait_line(output int lat);
    lat = 1;
    while (!o_fetch_valid && lat < 300) begin
      @(posedge i_clk); #1; lat++;
    end
    chk("line_timeout", 64'(o_fetch_valid), 64'd1);
  endtask

  task automatic check_line(input logic [31:0] base);
    for (int k = 0; k < LS; k++)
      chk("line_word", 64'(o_fetch_data[k]), 64'(mem_word(base + 32'(k))));
    chk("issued_count", 64'(issued.size()), 64'(LS));
    for (int k = 0; k < issued.size() && k < LS; k++)
      chk("issued_addr", 64'(issued[k]), 64'(base + 32'(k)));
  endtask

  // Hold the line for 'hold' cycles, then consume it.
  task automatic ack(input int hold);
    logic [31:0] snap [LS];
    for (int k = 0; k < LS; k++) snap[k] = o_fetch_data[k];
    for (int c = 0; c < hold; c++) begin
      @(posedge i_clk); #1;
      chk("hold_valid", 64'(o_fetch_valid), 64'd1);
      chk("hold_fetch_ready", 64'(o_fetch_ready), 64'd0);
      for (int k = 0; k < LS; k++)
        chk("hold_data", 64'(o_fetch_data[k]), 64'(snap[k]));
    end
    i_fetch_ready = 1'b1;
    @(posedge i_clk); #1;
    i_fetch_ready = 1'b0;
    chk("ack_valid_low", 64'(o_fetch_valid), 64'd0);
    chk("ack_ready_high", 64'(o_fetch_ready), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int          lat;
    int          n;
    logic [31:0] addr;
    logic [31:0] snap [LS];

    // Reset values
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_fetch_ready", 64'(o_fetch_ready), 64'd0);
    chk("rst_fetch_valid", 64'(o_fetch_valid), 64'd0);
    chk("rst_mem_valid", 64'(o_mem_valid), 64'd0);
    chk("rst_mem_rready", 64'(o_mem_rready), 64'd0);
    chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    for (int k = 0; k < LS; k++) chk("rst_data", 64'(o_fetch_data[k]), 64'd0);
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("idle_ready", 64'(o_fetch_ready), 64'd1);

    // Basic fill, zero-wait memory, mem[a] = a
    salt = '0;
    request(32'h1236, 1'b0);
    chk("busy_fetch_ready", 64'(o_fetch_ready), 64'd0);
    chk("first_addr", 64'(o_mem_addr), 64'h1234);
    wait_line(lat);
    chk("lat_basic", 64'(lat), 64'(LS + 2));
    check_line(32'h1234);
    ack(0);

    // Memory stall of 3 cycles on beat 1
    @(negedge i_clk);
    ready_seq.push_back(1'b1);
    repeat (3) ready_seq.push_back(1'b0);
    request(32'h2000, 1'b0);
    wait_line(lat);
    chk("lat_stall", 64'(lat), 64'(LS + 2 + 3));
    check_line(32'h2000);

    // Cache backpressure in DONE for 5 cycles
    ack(5);

    // Stray read data while idle must be ignored
    for (int k = 0; k < LS; k++) snap[k] = o_fetch_data[k];
    @(negedge i_clk);
    inj_data  = 32'hDEAD;
    inj_valid = 1'b1;
    @(negedge i_clk);
    inj_valid = 1'b0;
    chk("idle_rready", 64'(o_mem_rready), 64'd0);
    @(posedge i_clk); #1;
    for (int k = 0; k < LS; k++) chk("idle_buf", 64'(o_fetch_data[k]), 64'(snap[k]));
    chk("idle_no_line", 64'(o_fetch_valid), 64'd0);
    request(32'h0100, 1'b0);
    wait_line(lat);
    chk("lat_after_stray", 64'(lat), 64'(LS + 2));
    check_line(32'h0100);
    ack(0);

    // Reset mid-fill after two response beats
    request(32'h0080, 1'b0);
    rsp_seen = 0;
    n = 0;
    while (rsp_seen < 2 && n < 50) begin
      @(posedge i_clk); #1; n++;
    end
    chk("rst_mid_beats", 64'(rsp_seen >= 2), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_fetch_ready", 64'(o_fetch_ready), 64'd0);
    chk("mid_rst_fetch_valid", 64'(o_fetch_valid), 64'd0);
    chk("mid_rst_mem_valid", 64'(o_mem_valid), 64'd0);
    chk("mid_rst_mem_rready", 64'(o_mem_rready), 64'd0);
    chk("mid_rst_mem_addr", 64'(o_mem_addr), 64'd0);
    for (int k = 0; k < LS; k++) chk("mid_rst_data", 64'(o_fetch_data[k]), 64'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge i_clk); #1;
      chk("post_rst_no_line", 64'(o_fetch_valid), 64'd0);
      chk("post_rst_no_req", 64'(o_mem_valid), 64'd0);
    end
    request(32'h0040, 1'b0);
    wait_line(lat);
    chk("lat_post_rst", 64'(lat), 64'(LS + 2));
    check_line(32'h0040);
    ack(0);

    // Back-to-back fills with i_fetch_valid held high
    request(32'h0010, 1'b1);
    i_fetch_addr = 32'h0020;
    wait_line(lat);
    chk("lat_b2b_first", 64'(lat), 64'(LS + 2));
    check_line(32'h0010);
    ack(0);
    @(posedge i_clk); #1;
    i_fetch_valid = 1'b0;
    issued.delete();
    chk("b2b_accepted", 64'(o_fetch_ready), 64'd0);
    chk("b2b_mem_valid", 64'(o_mem_valid), 64'd1);
    chk("b2b_mem_addr", 64'(o_mem_addr), 64'h0020);
    wait_line(lat);
    chk("lat_b2b_second", 64'(lat), 64'(LS + 2));
    check_line(32'h0020);
    ack(0);

    // Randomized fills: random addresses, contents, memory stalls and cache backpressure
    rand_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      salt = $urandom;
      addr = $urandom;
      request(addr, 1'b0);
      wait_line(lat);
      check_line(addr & ~32'(LS - 1));
      ack(int'($urandom_range(0, 3)));
    end
    rand_ready = 1'b0;

    repeat (4) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kv_line_fill.md
KV_LINE_FILL -- requirements
Module: kv_line_fill

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one memory word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, word address width.
REQ-003 SHALL have parameter LINE_SIZE, default 4, words per cache line; power of two, >= 2; OFS = clog2(LINE_SIZE).
REQ-004 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_fetch_addr  input  ADDR_WIDTH  miss address from the cache.
REQ-007 SHALL have port i_fetch_valid  input  1  fill request valid.
REQ-008 SHALL have port o_fetch_ready  output  1  fill request accepted.
REQ-009 SHALL have port o_fetch_data  output  DATA_WIDTH x LINE_SIZE (unpacked)  assembled line; element k = word at offset k.
REQ-010 SHALL have port o_fetch_valid  output  1  line valid.
REQ-011 SHALL have port i_fetch_ready  input  1  cache consumes the line.
REQ-012 SHALL have port o_mem_addr  output  ADDR_WIDTH  memory word read address.
REQ-013 SHALL have port o_mem_valid  output  1  memory read request valid.
REQ-014 SHALL have port i_mem_ready  input  1  memory accepts the request.
REQ-015 SHALL have port i_mem_rdata  input  DATA_WIDTH  read data.
REQ-016 SHALL have port i_mem_rvalid  input  1  read data valid; responses return in request order.
REQ-017 SHALL have port o_mem_rready  output  1  block accepts read data.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-019 SHALL, in IDLE, drive o_fetch_ready=1; on i_fetch_valid&o_fetch_ready, latch base = i_fetch_addr with low OFS bits cleared, clear req_cnt and rsp_cnt, and go to BUSY.
REQ-020 SHALL, in BUSY, drive o_mem_valid=1 while req_cnt < LINE_SIZE, with o_mem_addr = base | req_cnt[OFS-1:0]; req_cnt increments on o_mem_valid&i_mem_ready.
REQ-021 SHALL keep o_mem_addr and o_mem_valid stable while o_mem_valid=1 and i_mem_ready=0.
REQ-022 SHALL use counters of OFS+1 bits; req_cnt saturates at LINE_SIZE; no wrap.
REQ-023 SHALL drive o_mem_rready=1 only in BUSY; on i_mem_rvalid&o_mem_rready, write i_mem_rdata into buffer slot rsp_cnt and increment rsp_cnt.
REQ-024 SHALL go BUSY->DONE on the beat that makes rsp_cnt = LINE_SIZE; request and response beats in the same cycle are both taken.
REQ-025 SHALL, in DONE, drive o_fetch_valid=1 with o_fetch_data = buffer, held stable until i_fetch_ready=1, then return to IDLE.
REQ-026 SHALL drive o_fetch_ready=0 in BUSY and DONE; a new request is accepted no earlier than the cycle after the DONE handshake.
REQ-027 SHALL ignore i_mem_rvalid outside BUSY and i_fetch_addr changes outside IDLE.
REQ-028 SHALL, with i_mem_ready=1 and data returned the cycle after request acceptance, assert o_fetch_valid exactly LINE_SIZE+2 cycles after the request handshake.

Reset
REQ-029 SHALL, while i_rst=1, force state IDLE, counters 0, buffer 0, o_fetch_valid=0, o_mem_valid=0, o_mem_rready=0, o_fetch_ready=0, o_mem_addr=0.
REQ-030 SHALL, on reset mid-fill, discard the partial line and stay in IDLE after release; no o_fetch_valid for the aborted request.

Verification
REQ-031 SHALL cover: request addr 0x1236, zero-wait memory returning mem[a]=a -> o_mem_addr 0x1234..0x1237, o_fetch_data {0x1234,0x1235,0x1236,0x1237}, o_fetch_valid at cycle 6.
REQ-032 SHALL cover: i_mem_ready low 3 cycles on beat 1 -> o_mem_addr/o_mem_valid held, line correct, o_fetch_valid delayed 3 cycles.
REQ-033 SHALL cover: i_fetch_ready low 5 cycles in DONE -> o_fetch_valid and o_fetch_data stable, o_fetch_ready=0 throughout.
REQ-034 SHALL cover: i_mem_rvalid pulsed in IDLE with data 0xDEAD -> o_mem_rready=0, buffer unchanged, next fill unaffected.
REQ-035 SHALL cover: i_rst asserted after 2 response beats -> all outputs at REQ-029 values immediately, a following fill of 0x40 returns a clean line.
REQ-036 SHALL cover: two back-to-back fills (0x10, 0x20) with i_fetch_valid held -> second accepted one cycle after the first DONE handshake.
